wide_addsub_seq: RTL and testbench
==================================

# wide_addsub_seq

Multi-cycle sequencer that performs 16·WORDS-bit add/subtract by streaming operand slices, least-significant first, through one 16-bit carry-lookahead slice adder, one slice per clock. The carry is registered between slices. Final carry-out and overflow are computed from the top slice. It sits between a wide-operand requester (address/accumulator logic) and the team's 16-bit CLA datapath. Wide arithmetic reuses a single 16-bit adder instead of instantiating a full-width one.

## Interface
- WORDS, 4, number of 16-bit slices; operand width N = 16·WORDS; legal range 1..16
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- a  input  N  operand A
- b  input  N  operand B
- sub  input  1  0 = A+B, 1 = A−B
- sign  input  1  0 = unsigned overflow semantics, 1 = two's-complement semantics
- ready  output  1  idle, will accept start
- done  output  1  one-cycle pulse: result valid
- sum  output  N  result mod 2^N
- co  output  1  carry out of bit N−1
- of  output  1  overflow flag

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE→RUN on start=1. In the same edge: capture a, b, sub, sign into operand registers; set slice index idx=0; set carry register = sub.
  - RUN, one slice per edge, for slice idx:
    - operand_b = sub ? ~b_slice : b_slice
    - {c_out, s} = a_slice + operand_b + carry
    - write s into sum[16·idx+15 : 16·idx]
    - carry ← c_out
    - idx ← idx+1
  - RUN→DONE on the edge that processes idx = WORDS−1. On that edge: co ← c_out; of computed per the rule below; c15 is the carry into bit 15 of the top slice.
  - DONE→IDLE unconditionally after one cycle.
- **Overflow rule:**
  - sign=1: of = c15 XOR c_out
  - sign=0, add: of = c_out
  - sign=0, sub: of = NOT c_out (borrow)
- **Outputs:**
  - ready = (state==IDLE)
  - done = (state==DONE)
  - sum, co, of are registered. They hold their last result until the next accepted start.
  - During RUN, sum is partially updated and not valid; done is the only valid qualifier.
- **Boundary conditions:**
  - start while RUN or DONE: ignored, not queued; a/b changes during that time have no effect.
  - start held high continuously: a new operation is accepted each time the FSM reaches IDLE.
  - WORDS=1: a single RUN cycle.
  - idx width is clog2(WORDS), minimum 1 bit.
  - Reset asserted at any time, including mid-operation: immediately returns state=IDLE, ready=1, done=0, sum=0, co=0, of=0, idx=0, carry=0. The partial result is discarded.
- **Reset values:** ready=1, done=0, sum=0, co=0, of=0.

## Timing
- start sampled high at edge E0.
- RUN slices are processed at edges E1..E(WORDS).
- done=1 between E(WORDS) and E(WORDS+1).
- ready returns to 1 after E(WORDS+1).
- Latency start→done = WORDS edges after acceptance. Throughput = one operation per WORDS+2 cycles.
- No combinational path from inputs to outputs.
- Slice adder is combinational within one cycle: 16-bit CLA plus the operand-invert mux.

## Structure
- **Package wide_addsub_pkg:**
  - SLICE_W = 16
  - state enum {IDLE, RUN, DONE}
  - function computing the overflow rule from (sign, sub, c15, c_out)
- **Sub-module addsub_slice16:** combinational 16-bit CLA slice.
  - Inputs: a, b, cin.
  - Outputs: s, cout, c15 (carry into bit 15).
  - Built from 4-bit lookahead groups with group propagate/generate.
  - Instantiated once.
- **Top:** FSM, idx counter, carry register, operand registers, result slice write-enable decode.

## Test plan
- **Cross-slice carry:** WORDS=4, a=0x0000_0000_0000_FFFF, b=1, sub=0, sign=1 → sum=0x0000_0000_0001_0000, co=0, of=0. done exactly 4 edges after start; ready low for 5 cycles.
- **Unsigned borrow:** a=5, b=7, sub=1, sign=0 → sum=0xFFFF_FFFF_FFFF_FFFE, co=0, of=1.
- **Signed overflow:** a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0, sign=1 → sum=0x8000_0000_0000_0000, co=0, of=1. Same operands with sign=0 → of=0.
- **start while busy:** pulse start with new a/b at edges E2 and E3 of a running operation → ignored; first result unchanged. start held high → second operation accepted at the first IDLE edge; its done lands 6 cycles after the first done.
- **Reset mid-operation:** drop rst_n between E2 and E3 → same cycle: ready=1, done=0, sum=0, co=0, of=0. After release, a fresh a=3, b=4 add yields sum=7.
- **Single-slice configuration:** WORDS=1, a=0x8000, b=0x8000, sub=0, sign=1 → sum=0x0000, co=1, of=1; done one edge after start.

Source files
------------

// File: rtl/wide_addsub_seq_pkg.sv
// Shared types, constants and the overflow rule for the wide add/sub sequencer.
package wide_addsub_pkg;

   localparam int SLICE_W = 16;
   localparam int GROUP_W = 4;
   localparam int GROUPS  = SLICE_W / GROUP_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Overflow flag from the top slice: signed uses the carry into/out of the
   // sign bit, unsigned add reports carry-out, unsigned sub reports borrow.
   function automatic logic calc_of(input logic i_sign,
                                    input logic i_sub,
                                    input logic i_c15,
                                    input logic i_cout);
      logic v_of;
      if (i_sign) begin
         v_of = i_c15 ^ i_cout;
      end else if (i_sub) begin
         v_of = ~i_cout;
      end else begin
         v_of = i_cout;
      end
      return v_of;
   endfunction

endpackage

// File: rtl/wide_addsub_seq_if.sv
// Request/result bundle between the wide-operand requester and the sequencer.
interface wide_addsub_seq_if
   import wide_addsub_pkg::*;
#(
   parameter int WORDS = 4
) ();

   logic                       start;
   logic [SLICE_W*WORDS-1:0]   a;
   logic [SLICE_W*WORDS-1:0]   b;
   logic                       sub;
   logic                       sign;
   logic                       ready;
   logic                       done;
   logic [SLICE_W*WORDS-1:0]   sum;
   logic                       co;
   logic                       of;

   modport master (
      output start, a, b, sub, sign,
      input  ready, done, sum, co, of
   );

   modport slave (
      input  start, a, b, sub, sign,
      output ready, done, sum, co, of
   );

endinterface

// File: rtl/wide_addsub_seq_slice16.sv
// Combinational 16-bit carry-lookahead slice built from four 4-bit groups.
// Also exposes the carry into bit 15 so the caller can form signed overflow.
module addsub_slice16
   import wide_addsub_pkg::*;
(
   input  logic [SLICE_W-1:0] i_a,
   input  logic [SLICE_W-1:0] i_b,
   input  logic               i_cin,
   output logic [SLICE_W-1:0] o_s,
   output logic               o_cout,
   output logic               o_c15
);

   logic [SLICE_W-1:0] w_g;
   logic [SLICE_W-1:0] w_p;
   logic [GROUPS-1:0]  w_gg;
   logic [GROUPS-1:0]  w_gp;
   logic [GROUPS:0]    w_cg;
   logic [SLICE_W-1:0] w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Group generate/propagate for each 4-bit group.
   always_comb begin
      w_gg = {GROUPS{1'b0}};
      w_gp = {GROUPS{1'b0}};
      for (int k = 0; k < GROUPS; k++) begin
         w_gp[k] = &w_p[GROUP_W*k +: GROUP_W];
         w_gg[k] = w_g[GROUP_W*k+3]
                 | (w_p[GROUP_W*k+3] & w_g[GROUP_W*k+2])
                 | (w_p[GROUP_W*k+3] & w_p[GROUP_W*k+2] & w_g[GROUP_W*k+1])
                 | (w_p[GROUP_W*k+3] & w_p[GROUP_W*k+2] & w_p[GROUP_W*k+1] & w_g[GROUP_W*k]);
      end
   end

   // Second-level lookahead: every group carry-in straight from cin.
   assign w_cg[0] = i_cin;
   assign w_cg[1] = w_gg[0] | (w_gp[0] & i_cin);
   assign w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
   assign w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
   assign w_cg[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

   // Bit carries inside each group, seeded by that group's lookahead carry.
   always_comb begin
      logic [SLICE_W-1:0] v_c;
      v_c = {SLICE_W{1'b0}};
      for (int k = 0; k < GROUPS; k++) begin
         v_c[GROUP_W*k] = w_cg[k];
         for (int j = 1; j < GROUP_W; j++) begin
            v_c[GROUP_W*k+j] = w_g[GROUP_W*k+j-1] | (w_p[GROUP_W*k+j-1] & v_c[GROUP_W*k+j-1]);
         end
      end
      w_c = v_c;
   end

   assign o_s    = w_p ^ w_c;
   assign o_cout = w_cg[GROUPS];
   assign o_c15  = w_c[SLICE_W-1];

endmodule

// File: rtl/wide_addsub_seq.sv
// Wide add/subtract sequencer: streams 16-bit slices LSB-first through one
// CLA slice, one slice per clock, with the carry registered between slices.
module wide_addsub_seq
   import wide_addsub_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   wide_addsub_seq_if.slave bus
);

   localparam int                N        = SLICE_W * WORDS;
   localparam int                IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic               r_carry;
   logic [N-1:0]       r_a;
   logic [N-1:0]       r_b;
   logic               r_sub;
   logic               r_sign;
   logic [N-1:0]       r_sum;
   logic               r_co;
   logic               r_of;
   logic               r_ready;
   logic               r_done;

   int                 w_base;
   logic [SLICE_W-1:0] w_a_slice;
   logic [SLICE_W-1:0] w_b_slice;
   logic [SLICE_W-1:0] w_b_op;
   logic [SLICE_W-1:0] w_s;
   logic               w_cout;
   logic               w_c15;
   logic [WORDS-1:0]   w_we;

   assign w_base    = int'(r_idx) * SLICE_W;
   assign w_a_slice = r_a[w_base +: SLICE_W];
   assign w_b_slice = r_b[w_base +: SLICE_W];

   // Subtraction adds the inverted B slice; the +1 comes from the initial carry.
   always_comb begin
      if (r_sub) begin
         w_b_op = ~w_b_slice;
      end else begin
         w_b_op = w_b_slice;
      end
   end

   addsub_slice16 u_slice (
      .i_a    (w_a_slice),
      .i_b    (w_b_op),
      .i_cin  (r_carry),
      .o_s    (w_s),
      .o_cout (w_cout),
      .o_c15  (w_c15)
   );

   // One-hot write enable for the result slice being produced this cycle.
   always_comb begin
      w_we = {WORDS{1'b0}};
      if (r_state == RUN) begin
         for (int k = 0; k < WORDS; k++) begin
            w_we[k] = (r_idx == IDX_W'(k));
         end
      end else begin
         w_we = {WORDS{1'b0}};
      end
   end

   // Sequencer: accept, walk the slices, flag completion, return to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_sub   <= 1'b0;
         r_sign  <= 1'b0;
         r_co    <= 1'b0;
         r_of    <= 1'b0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_sub   <= bus.sub;
                  r_sign  <= bus.sign;
                  r_idx   <= '0;
                  r_carry <= bus.sub;
                  r_state <= RUN;
                  r_ready <= 1'b0;
               end
            end
            RUN: begin
               r_carry <= w_cout;
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_co    <= w_cout;
                  r_of    <= calc_of(r_sign, r_sub, w_c15, w_cout);
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_idx   <= '0;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Result register: each slice is written once, in the cycle it is computed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum <= '0;
      end else begin
         for (int k = 0; k < WORDS; k++) begin
            if (w_we[k]) begin
               r_sum[k*SLICE_W +: SLICE_W] <= w_s;
            end
         end
      end
   end

   assign bus.ready = r_ready;
   assign bus.done  = r_done;
   assign bus.sum   = r_sum;
   assign bus.co    = r_co;
   assign bus.of    = r_of;

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Directed bench for wide_addsub_seq: a 4-slice and a 1-slice instance.
module tb_wide_addsub_seq;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   wide_addsub_seq_if #(.WORDS(4)) if4 ();
   wide_addsub_seq_if #(.WORDS(1)) if1 ();

   wide_addsub_seq #(.WORDS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
   wide_addsub_seq #(.WORDS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one operation and follow it until ready returns, measuring timing.
   task automatic run_op(input bit sel, input logic [63:0] ta, input logic [63:0] tb,
                         input logic tsub, input logic tsign,
                         output int dlat, output int rlow, output int dpulse);
      logic rdy;
      logic dn;
      @(negedge clk);
      if (sel) begin
         if1.a = ta[15:0]; if1.b = tb[15:0]; if1.sub = tsub; if1.sign = tsign; if1.start = 1'b1;
      end else begin
         if4.a = ta; if4.b = tb; if4.sub = tsub; if4.sign = tsign; if4.start = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if1.start = 1'b0;
      if4.start = 1'b0;
      dlat = -1; rlow = 0; dpulse = 0;
      rdy = sel ? if1.ready : if4.ready;
      while (rdy === 1'b0 && rlow < 20) begin
         dn = sel ? if1.done : if4.done;
         if (dn === 1'b1) begin
            dpulse++;
            dlat = rlow;
         end
         rlow++;
         @(negedge clk);
         rdy = sel ? if1.ready : if4.ready;
      end
   endtask

   initial begin
      int dlat, rlow, dpulse, cnt;
      checks = 0; errors = 0;
      rst_n = 1'b0;
      if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.sub = 1'b0; if4.sign = 1'b0;
      if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.sub = 1'b0; if1.sign = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_ready", {63'd0, if4.ready}, 64'd1);
      chk("rst_done",  {63'd0, if4.done},  64'd0);
      chk("rst_sum",   if4.sum,            64'd0);
      chk("rst_co",    {63'd0, if4.co},    64'd0);
      chk("rst_of",    {63'd0, if4.of},    64'd0);
      chk("rst1_ready", {63'd0, if1.ready}, 64'd1);
      rst_n = 1'b1;

      // Carry ripples from slice 0 into slice 1.
      run_op(1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b1, dlat, rlow, dpulse);
      chk("xc_done_lat", 64'(dlat),   64'd4);
      chk("xc_ready_low", 64'(rlow),  64'd5);
      chk("xc_done_width", 64'(dpulse), 64'd1);
      chk("xc_sum", if4.sum, 64'h0000_0000_0001_0000);
      chk("xc_co",  {63'd0, if4.co}, 64'd0);
      chk("xc_of",  {63'd0, if4.of}, 64'd0);

      // Unsigned borrow.
      run_op(1'b0, 64'd5, 64'd7, 1'b1, 1'b0, dlat, rlow, dpulse);
      chk("ub_sum", if4.sum, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("ub_co",  {63'd0, if4.co}, 64'd0);
      chk("ub_of",  {63'd0, if4.of}, 64'd1);

      // Signed overflow, then the same operands as unsigned.
      run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, dlat, rlow, dpulse);
      chk("so_sum", if4.sum, 64'h8000_0000_0000_0000);
      chk("so_co",  {63'd0, if4.co}, 64'd0);
      chk("so_of",  {63'd0, if4.of}, 64'd1);
      run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, dlat, rlow, dpulse);
      chk("uo_of",  {63'd0, if4.of}, 64'd0);

      // Unsigned add wrapping past 2^64.
      run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, dlat, rlow, dpulse);
      chk("wr_sum", if4.sum, 64'd0);
      chk("wr_co",  {63'd0, if4.co}, 64'd1);
      chk("wr_of",  {63'd0, if4.of}, 64'd1);

      // Equal operands subtracted: no borrow.
      run_op(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, dlat, rlow, dpulse);
      chk("eq_sum", if4.sum, 64'd0);
      chk("eq_co",  {63'd0, if4.co}, 64'd1);
      chk("eq_of",  {63'd0, if4.of}, 64'd0);

      // Start pulsed with new operands at E2 and E3 of a running operation.
      @(negedge clk);
      if4.a = 64'd10; if4.b = 64'd20; if4.sub = 1'b0; if4.sign = 1'b0; if4.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if4.start = 1'b0;
      @(negedge clk);
      if4.start = 1'b1; if4.a = 64'hFFFF_FFFF_FFFF_FFFF; if4.b = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      if4.start = 1'b0;
      cnt = 0;
      while (if4.done !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("busy_done_seen", {63'd0, if4.done}, 64'd1);
      chk("busy_sum", if4.sum, 64'd30);
      @(negedge clk);
      @(negedge clk);
      chk("busy_not_queued", {63'd0, if4.ready}, 64'd1);

      // Start held high: back-to-back operations six cycles apart.
      @(negedge clk);
      if4.a = 64'd1; if4.b = 64'd2; if4.sub = 1'b0; if4.sign = 1'b0; if4.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if4.a = 64'd100; if4.b = 64'd200;
      cnt = 0;
      while (if4.done !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("held_first_sum", if4.sum, 64'd3);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (if4.done !== 1'b1 && cnt < 20);
      if4.start = 1'b0;
      chk("held_gap", 64'(cnt), 64'd6);
      chk("held_second_sum", if4.sum, 64'd300);
      @(negedge clk);
      @(negedge clk);

      // Reset dropped between E2 and E3.
      @(negedge clk);
      if4.a = 64'hFFFF_FFFF_FFFF_FFFF; if4.b = 64'hFFFF_FFFF_FFFF_FFFF; if4.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if4.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_ready", {63'd0, if4.ready}, 64'd1);
      chk("mr_done",  {63'd0, if4.done},  64'd0);
      chk("mr_sum",   if4.sum,            64'd0);
      chk("mr_co",    {63'd0, if4.co},    64'd0);
      chk("mr_of",    {63'd0, if4.of},    64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, 64'd3, 64'd4, 1'b0, 1'b0, dlat, rlow, dpulse);
      chk("mr_after_lat", 64'(dlat), 64'd4);
      chk("mr_after_sum", if4.sum, 64'd7);

      // Single-slice instance.
      run_op(1'b1, 64'h8000, 64'h8000, 1'b0, 1'b1, dlat, rlow, dpulse);
      chk("w1_done_lat", 64'(dlat), 64'd1);
      chk("w1_ready_low", 64'(rlow), 64'd2);
      chk("w1_sum", {48'd0, if1.sum}, 64'h0000);
      chk("w1_co",  {63'd0, if1.co}, 64'd1);
      chk("w1_of",  {63'd0, if1.of}, 64'd1);
      run_op(1'b1, 64'h0003, 64'h0005, 1'b1, 1'b1, dlat, rlow, dpulse);
      chk("w1s_sum", {48'd0, if1.sum}, 64'hFFFE);
      chk("w1s_co",  {63'd0, if1.co}, 64'd0);
      chk("w1s_of",  {63'd0, if1.of}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
